// File: rtl/mod241_pkg.sv
// Shared constants for the mod-241 residue blocks: modulus, fold constant,
// chunk width, reducer state encoding and the chunk-count helper.
package mod241_pkg;

  localparam int MOD    = 241;
  localparam int FOLD_K = 15;   // 2^8 mod 241
  localparam int CHUNK  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mod241_state_e;

  // Number of CHUNK-bit digits needed to cover a w-bit operand.
  function automatic int nchunk(input int w);
    return (w + CHUNK - 1) / CHUNK;
  endfunction

endpackage

// File: rtl/mod241_fold.sv
// Combinational reduction of a 14-bit value to its canonical residue mod 241.
// Two folds using 256 == 15 (mod 241) bring the value to at most 315, then a
// single conditional subtract finishes the job.
module mod241_fold
  import mod241_pkg::*;
(
  input  logic [13:0] v_i,
  output logic [7:0]  r_o
);

  logic [10:0] s1;
  logic [8:0]  s2;

  // Fold the high byte twice, then one conditional subtract.
  always_comb begin
    s1  = 11'(v_i[13:8]) * 11'(FOLD_K) + 11'(v_i[7:0]);
    s2  = 9'(s1[10:8]) * 9'(FOLD_K) + 9'(s1[7:0]);
    r_o = (s2 >= 9'(MOD)) ? 8'(s2 - 9'(MOD)) : s2[7:0];
  end

endmodule

// File: rtl/mod241_reduce_seq.sv
// Sequential modulo-241 reducer. Walks a W-bit operand MS chunk first,
// six bits per clock, in Horner form through one shared fold stage.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a new operand
// RUN     | consuming one 6-bit chunk per cycle
// DONE    | residue presented on out_data, waiting for out_ready
module mod241_reduce_seq #(
  parameter int W     = 48,
  parameter int CHUNK = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         busy
);
  import mod241_pkg::*;

  localparam int NCHUNK = nchunk(W);
  localparam int SRW    = NCHUNK * 6;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;

  if (CHUNK != 6) begin : g_chunk_chk
    $error("mod241_reduce_seq: CHUNK must be 6");
  end
  if (W < 1) begin : g_width_chk
    $error("mod241_reduce_seq: W must be at least 1");
  end

  logic [1:0]     state_q, state_d;
  logic [SRW-1:0] sr_q, sr_d;
  logic [7:0]     acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     fold_r;

  // acc*64 + chunk is exactly the concatenation, and stays below 16384.
  mod241_fold u_fold (
    .v_i ({acc_q, sr_q[SRW-1 -: 6]}),
    .r_o (fold_r)
  );

  // Next-state logic for the handshake FSM and the Horner datapath.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sr_d    = SRW'(in_data);
          acc_d   = 8'd0;
          cnt_d   = CW'(NCHUNK - 1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = fold_r;
        sr_d  = sr_q << 6;
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any operand in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = acc_q;

endmodule

// File: tb/tb_mod241_reduce_seq.sv
// Bench for mod241_reduce_seq: directed cases on a W=48 instance, then
// randomized traffic on W=48 and W=13 instances against operand % 241.
module tb_mod241_reduce_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [47:0] in_data_a;
  logic [7:0]  out_data_a;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [12:0] in_data_b;
  logic [7:0]  out_data_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod241_reduce_seq #(.W(48)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .busy(busy_a)
  );

  mod241_reduce_seq #(.W(13)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .busy(busy_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operand through the W=48 instance with a fixed 8-cycle latency check.
  task automatic run_op(input logic [47:0] d, input logic [7:0] exp, input string tag);
    int n;
    n = 0;
    while (!in_ready_a && n < 50) begin step(); n++; end
    check({tag, "_rdy"}, 64'(in_ready_a), 64'd1);
    in_valid_a = 1'b1;
    in_data_a  = d;
    step();
    in_valid_a = 1'b0;
    in_data_a  = '0;
    check({tag, "_run"}, 64'(in_ready_a), 64'd0);
    n = 0;
    while (!out_valid_a && n < 50) begin step(); n++; end
    check({tag, "_lat"}, 64'(n), 64'd8);
    check({tag, "_data"}, 64'(out_data_a), 64'(exp));
    out_ready_a = 1'b1;
    step();
    out_ready_a = 1'b0;
    check({tag, "_idle"}, 64'(busy_a), 64'd0);
  endtask

  initial begin
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [63:0] r64;
    int          sent_a, sent_b, got_a, got_b, cyc;
    localparam int NRAND = 2000;

    rst = 1'b1;
    in_valid_a = 0; in_data_a = '0; out_ready_a = 0;
    in_valid_b = 0; in_data_b = '0; out_ready_b = 0;
    step(); step();
    rst = 1'b0;
    step();

    check("rst_in_ready",  64'(in_ready_a),  64'd1);
    check("rst_out_valid", 64'(out_valid_a), 64'd0);
    check("rst_out_data",  64'(out_data_a),  64'd0);
    check("rst_busy",      64'(busy_a),      64'd0);
    check("rst_b_ready",   64'(in_ready_b),  64'd1);
    check("rst_b_busy",    64'(busy_b),      64'd0);

    run_op(48'h0,            8'd0,   "zero");
    run_op(48'd241,          8'd0,   "d241");
    run_op(48'd242,          8'd1,   "d242");
    run_op(48'd240,          8'd240, "d240");
    run_op(48'hFFF,          8'd239, "fff");
    run_op(48'h000001000000, 8'd1,   "p24");
    run_op(48'hFFFFFFFFFFFF, 8'd0,   "ones");

    // Backpressure: hold DONE for 20 cycles with a stray in_valid pulse.
    in_valid_a = 1'b1; in_data_a = 48'd242;
    step();
    in_valid_a = 1'b0;
    cyc = 0;
    while (!out_valid_a && cyc < 50) begin step(); cyc++; end
    check("bp_reach_done", 64'(out_valid_a), 64'd1);
    for (int i = 0; i < 20; i++) begin
      in_valid_a = (i == 5);
      in_data_a  = (i == 5) ? 48'd5 : 48'd0;
      step();
      check("bp_hold_data",  64'(out_data_a),  64'd1);
      check("bp_hold_valid", 64'(out_valid_a), 64'd1);
      check("bp_in_ready",   64'(in_ready_a),  64'd0);
    end
    in_valid_a = 1'b0; in_data_a = '0;
    out_ready_a = 1'b1;
    step();
    out_ready_a = 1'b0;
    check("bp_release_valid", 64'(out_valid_a), 64'd0);
    check("bp_release_idle",  64'(in_ready_a),  64'd1);
    for (int i = 0; i < 12; i++) begin
      step();
      check("bp_no_ghost", 64'(out_valid_a | busy_a), 64'd0);
    end

    // Reset in the 4th RUN cycle aborts the operand.
    in_valid_a = 1'b1; in_data_a = 48'hFFFFFFFFFFFF;
    step();
    in_valid_a = 1'b0; in_data_a = '0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready",  64'(in_ready_a),  64'd1);
    check("abort_out_valid", 64'(out_valid_a), 64'd0);
    check("abort_out_data",  64'(out_data_a),  64'd0);
    check("abort_busy",      64'(busy_a),      64'd0);
    run_op(48'hFFF, 8'd239, "after_abort");

    // Randomized traffic on both widths, scored against operand % 241.
    sent_a = 0; sent_b = 0; got_a = 0; got_b = 0; cyc = 0;
    while ((got_a < NRAND || got_b < NRAND) && cyc < 70000) begin
      in_valid_a  = (sent_a < NRAND) && ($urandom_range(3) != 0);
      r64         = {$urandom, $urandom};
      case ($urandom_range(15))
        0:       in_data_a = 48'hFFFFFFFFFFFF;
        1:       in_data_a = 48'h0;
        2:       in_data_a = 48'(r64[7:0]);
        default: in_data_a = r64[47:0];
      endcase
      out_ready_a = ($urandom_range(2) != 0);
      in_valid_b  = (sent_b < NRAND) && ($urandom_range(3) != 0);
      in_data_b   = 13'($urandom);
      out_ready_b = ($urandom_range(2) != 0);

      if (in_valid_a && in_ready_a) begin
        qa.push_back(8'(64'(in_data_a) % 64'd241));
        sent_a++;
      end
      if (in_valid_b && in_ready_b) begin
        qb.push_back(8'(32'(in_data_b) % 32'd241));
        sent_b++;
      end
      if (out_valid_a && out_ready_a) begin
        if (qa.size() == 0) check("rand_a_extra", 64'(out_data_a), 64'hDEAD);
        else check("rand_a_data", 64'(out_data_a), 64'(qa.pop_front()));
        got_a++;
      end
      if (out_valid_b && out_ready_b) begin
        if (qb.size() == 0) check("rand_b_extra", 64'(out_data_b), 64'hDEAD);
        else check("rand_b_data", 64'(out_data_b), 64'(qb.pop_front()));
        got_b++;
      end
      step();
      cyc++;
    end
    in_valid_a = 0; out_ready_a = 0; in_valid_b = 0; out_ready_b = 0;
    check("rand_a_count", 64'(got_a), 64'(NRAND));
    check("rand_b_count", 64'(got_b), 64'(NRAND));
    check("rand_a_left",  64'(qa.size()), 64'd0);
    check("rand_b_left",  64'(qb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
